// File: rtl/endat_poll_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : endat_poll_sched
// Purpose  : EnDat transaction sequencer. Arbitrates periodic and software
//            requests, fires the sampler key, waits for the frame with a
//            timeout, captures the angle and enforces inter-frame recovery.
// Revision : 1.0 - initial release
// ============================================================================
module endat_poll_sched #(
  parameter int PERIOD_CYC  = 20000,
  parameter int TRIG_W      = 4,
  parameter int TIMEOUT_CYC = 10000,
  parameter int RECOV_CYC   = 2000,
  parameter int ANGLE_W     = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sw_req,
  input  logic               smp_done,
  input  logic [ANGLE_W-1:0] smp_angle,
  output logic               smp_key,
  output logic [ANGLE_W-1:0] angle,
  output logic               angle_vld,
  output logic               angle_src,
  output logic               busy,
  output logic               err_timeout,
  output logic [15:0]        err_cnt,
  output logic               stale
);

  // Period counter width (PERIOD_CYC >= 2 keeps $clog2 >= 1)
  localparam int PER_W   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  // One shared phase counter serves TRIG, WAIT and RECOV
  localparam int MAX_TW  = (TRIG_W > TIMEOUT_CYC) ? TRIG_W : TIMEOUT_CYC;
  localparam int CNT_MAX = (MAX_TW > RECOV_CYC) ? MAX_TW : RECOV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_W - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOV_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRIG  = 2'd1,
    S_WAIT  = 2'd2,
    S_RECOV = 2'd3
  } state_t;

  state_t             state_q;
  logic [PER_W-1:0]   per_cnt_q;
  logic [PER_W-1:0]   per_cnt_d;
  logic               per_tick;
  logic [CNT_W-1:0]   cnt_q;
  logic               pend_per_q;
  logic               pend_sw_q;
  logic               src_q;
  logic               smp_key_q;
  logic [ANGLE_W-1:0] angle_q;
  logic               angle_vld_q;
  logic               angle_src_q;
  logic               busy_q;
  logic               err_timeout_q;
  logic [15:0]        err_cnt_q;
  logic               stale_q;

  // Poll timer next state: free-running wrap while enabled, held at 0 otherwise
  always_comb begin
    per_tick  = en && (per_cnt_q == PER_LAST);
    per_cnt_d = per_cnt_q + 1'b1;
    if (!en || per_tick) begin
      per_cnt_d = '0;
    end
  end

  // Poll timer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
    end
  end

  // Transaction FSM with request latching and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pend_per_q    <= 1'b0;
      pend_sw_q     <= 1'b0;
      src_q         <= 1'b0;
      smp_key_q     <= 1'b0;
      angle_q       <= '0;
      angle_vld_q   <= 1'b0;
      angle_src_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_cnt_q     <= '0;
      stale_q       <= 1'b0;
    end else begin
      angle_vld_q   <= 1'b0;
      err_timeout_q <= 1'b0;

      // One-deep latch per source; repeats merge, overflow is dropped
      if (sw_req) pend_sw_q <= 1'b1;
      if (!en) begin
        pend_per_q <= 1'b0;
      end else if (per_tick) begin
        pend_per_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          // A request seen in this same cycle is absorbed by this transaction
          if (pend_per_q || pend_sw_q || per_tick || sw_req) begin
            state_q    <= S_TRIG;
            smp_key_q  <= 1'b1;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            src_q      <= pend_sw_q | sw_req;
            pend_sw_q  <= 1'b0;
            pend_per_q <= 1'b0;
          end
        end
        S_TRIG: begin
          // smp_done here is deliberately ignored
          if (cnt_q == TRIG_LAST) begin
            state_q   <= S_WAIT;
            smp_key_q <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          // A frame arriving on the last timeout cycle still counts as good
          if (smp_done) begin
            angle_q     <= smp_angle;
            angle_src_q <= src_q;
            angle_vld_q <= 1'b1;
            stale_q     <= 1'b0;
            state_q     <= S_RECOV;
            cnt_q       <= '0;
          end else if (cnt_q == TMO_LAST) begin
            err_timeout_q <= 1'b1;
            stale_q       <= 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            state_q       <= S_RECOV;
            cnt_q         <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RECOV: begin
          if (cnt_q == RECOV_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          smp_key_q <= 1'b0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  assign smp_key     = smp_key_q;
  assign angle       = angle_q;
  assign angle_vld   = angle_vld_q;
  assign angle_src   = angle_src_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_cnt     = err_cnt_q;
  assign stale       = stale_q;

endmodule
`default_nettype wire

// File: tb/tb_endat_poll_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_endat_poll_sched
// Purpose  : Directed self-checking bench for endat_poll_sched with an angle
//            scoreboard fed at stimulus time and drained on angle_vld.
// Revision : 1.0 - initial release
// ============================================================================
module tb_endat_poll_sched;

  localparam int PERIOD = 100;
  localparam int TRIG   = 4;
  localparam int TMO    = 50;
  localparam int REC    = 10;
  localparam int AW     = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sw_req;
  logic          smp_done;
  logic [AW-1:0] smp_angle;
  logic          smp_key;
  logic [AW-1:0] angle;
  logic          angle_vld;
  logic          angle_src;
  logic          busy;
  logic          err_timeout;
  logic [15:0]   err_cnt;
  logic          stale;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          s;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   key_rise[$];
  int   err_cyc[$];
  int   errcnt_at[$];
  int   passes = 0;
  int   fails  = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   vld_seen = 0;
  int   s, c0, c1, c2, kcount, prev, vbase, ecount;

  always #5 clk = ~clk;

  endat_poll_sched #(
    .PERIOD_CYC (PERIOD),
    .TRIG_W     (TRIG),
    .TIMEOUT_CYC(TMO),
    .RECOV_CYC  (REC),
    .ANGLE_W    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sw_req     (sw_req),
    .smp_done   (smp_done),
    .smp_angle  (smp_angle),
    .smp_key    (smp_key),
    .angle      (angle),
    .angle_vld  (angle_vld),
    .angle_src  (angle_src),
    .busy       (busy),
    .err_timeout(err_timeout),
    .err_cnt    (err_cnt),
    .stale      (stale)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run n cycles, log key rises and timeouts, optionally answer each key after dly cycles
  task automatic run(input int n, input bit respond, input int dly,
                     input logic [AW-1:0] base, input logic src);
    int kr = -100000;
    int nresp = 0;
    int pk = smp_key;
    for (int i = 0; i < n; i++) begin
      tick();
      sw_req   = 1'b0;
      smp_done = 1'b0;
      if (smp_key && !pk) begin
        kr = cyc;
        key_rise.push_back(cyc);
      end
      pk = smp_key;
      if (err_timeout) begin
        err_cyc.push_back(cyc);
        errcnt_at.push_back(int'(err_cnt));
      end
      if (respond && cyc == kr + dly) begin
        smp_done  = 1'b1;
        smp_angle = base + AW'(nresp);
        exp_q.push_back('{a: base + AW'(nresp), s: src});
        nresp++;
      end
    end
  endtask

  // Scoreboard drain: every angle_vld must match the oldest expected capture
  always begin
    @(posedge clk);
    #1;
    if (angle_vld) begin
      vld_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_angle_vld", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_angle", 32'(angle), 32'(mon_e.a));
        chk("sb_angle_src", 32'(angle_src), 32'(mon_e.s));
      end
    end
  end

  // Hard time limit so the run can never hang
  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; sw_req = 1'b0; smp_done = 1'b0; smp_angle = '0;
    repeat (3) tick();
    // Reset state
    chk("rst_smp_key", 32'(smp_key), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_angle", 32'(angle), 32'd0);
    chk("rst_flags", {angle_vld, angle_src, err_timeout, stale}, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    repeat (5) tick();

    // Software request latency, capture and recovery length
    s = cyc;
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    for (int i = 0; i < TRIG; i++) begin
      chk("swA_key_high", 32'(smp_key), 32'd1);
      tick();
    end
    chk("swA_key_low_in_wait", 32'(smp_key), 32'd0);
    chk("swA_busy_wait", 32'(busy), 32'd1);
    while (cyc < s + 20) tick();
    smp_done = 1'b1;
    smp_angle = 21'h1ABCD;
    exp_q.push_back('{a: 21'h1ABCD, s: 1'b1});
    tick();
    smp_done = 1'b0;
    chk("swA_vld", 32'(angle_vld), 32'd1);
    chk("swA_angle", 32'(angle), 32'h1ABCD);
    chk("swA_src", 32'(angle_src), 32'd1);
    while (cyc < s + 30) tick();
    chk("swA_busy_last_recov", 32'(busy), 32'd1);
    tick();
    chk("swA_busy_fall", 32'(busy), 32'd0);

    // Periodic polling with a sampler answering 8 cycles after each key
    tick();
    en = 1'b1;
    c0 = cyc;
    vbase = vld_seen;
    key_rise.delete(); err_cyc.delete(); errcnt_at.delete();
    run(320, 1'b1, 8, 21'h100000, 1'b0);
    en = 1'b0;
    chk("per_key_count", 32'(key_rise.size()), 32'd3);
    for (int j = 0; j < 3; j++)
      chk("per_key_cycle", (j < key_rise.size()) ? 32'(key_rise[j] - c0) : 32'hFFFF_FFFF,
          32'(PERIOD * (j + 1)));
    chk("per_vld_count", 32'(vld_seen - vbase), 32'd3);
    chk("per_no_timeout", 32'(err_cyc.size()), 32'd0);

    // Periodic polling with no sampler response
    tick();
    en = 1'b1;
    c1 = cyc;
    key_rise.delete(); err_cyc.delete(); errcnt_at.delete();
    run(370, 1'b0, 0, '0, 1'b0);
    en = 1'b0;
    chk("tmo_count", 32'(err_cyc.size()), 32'd3);
    for (int j = 0; j < 3; j++) begin
      chk("tmo_cycle_after_key",
          (j < err_cyc.size() && j < key_rise.size()) ? 32'(err_cyc[j] - key_rise[j]) : 32'hFFFF_FFFF,
          32'(TRIG + TMO));
      chk("tmo_err_cnt", (j < errcnt_at.size()) ? 32'(errcnt_at[j]) : 32'hFFFF_FFFF, 32'(j + 1));
    end
    chk("tmo_stale_set", 32'(stale), 32'd1);
    // A good frame clears stale but leaves the error count alone
    sw_req = 1'b1;
    run(25, 1'b1, 8, 21'h0F0F0, 1'b1);
    chk("good_stale_clr", 32'(stale), 32'd0);
    chk("good_err_cnt_kept", 32'(err_cnt), 32'd3);

    // sw_req coinciding with per_tick, then a sw_req during WAIT
    tick();
    en = 1'b1;
    c2 = cyc;
    while (cyc < c2 + PERIOD - 1) tick();
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    en = 1'b0;
    chk("merge_key_start", 32'(smp_key), 32'd1);
    kcount = 0;
    prev = 1;
    for (int k = PERIOD + 1; k <= PERIOD + 19; k++) begin
      tick();
      sw_req = 1'b0;
      smp_done = 1'b0;
      if (smp_key && prev == 0) kcount++;
      prev = smp_key;
      if (k == PERIOD + 3) chk("merge_key_last", 32'(smp_key), 32'd1);
      if (k == PERIOD + 4) chk("merge_key_end", 32'(smp_key), 32'd0);
      if (k == PERIOD + 5) sw_req = 1'b1;
      if (k == PERIOD + 8) begin
        smp_done = 1'b1;
        smp_angle = 21'h0A5A5;
        exp_q.push_back('{a: 21'h0A5A5, s: 1'b1});
      end
    end
    chk("merge_single_burst", 32'(kcount), 32'd0);
    tick();
    chk("pend_sw_key_after_recov", 32'(smp_key), 32'd1);
    while (cyc < c2 + PERIOD + 28) tick();
    smp_done = 1'b1;
    smp_angle = 21'h1C3C3;
    exp_q.push_back('{a: 21'h1C3C3, s: 1'b1});
    tick();
    smp_done = 1'b0;
    repeat (15) tick();
    chk("pend_sw_done_idle", 32'(busy), 32'd0);

    // smp_done during TRIG is ignored; smp_done on the final timeout cycle wins
    tick();
    s = cyc;
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    tick();
    smp_done = 1'b1;
    smp_angle = 21'h15555;
    tick();
    smp_done = 1'b0;
    while (cyc < s + 5 + TMO - 1) tick();
    chk("trig_done_ignored_busy", 32'(busy), 32'd1);
    smp_done = 1'b1;
    smp_angle = 21'h0AAAA;
    exp_q.push_back('{a: 21'h0AAAA, s: 1'b1});
    tick();
    smp_done = 1'b0;
    chk("edge_vld", 32'(angle_vld), 32'd1);
    chk("edge_no_timeout", 32'(err_timeout), 32'd0);
    chk("edge_angle", 32'(angle), 32'h0AAAA);
    chk("edge_err_cnt", 32'(err_cnt), 32'd3);
    ecount = 0;
    repeat (15) begin
      tick();
      if (err_timeout) ecount++;
    end
    chk("edge_no_late_timeout", 32'(ecount), 32'd0);

    // Asynchronous reset in the middle of a key burst
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    tick();
    chk("arst_pre_key", 32'(smp_key), 32'd1);
    chk("arst_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_key", 32'(smp_key), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_angle", 32'(angle), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_flags", {angle_vld, angle_src, err_timeout, stale}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    kcount = 0;
    repeat (500) begin
      tick();
      if (smp_key) kcount++;
    end
    chk("post_rst_quiet", 32'(kcount), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("sb_vld_total", 32'(vld_seen), 32'd8);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
